// File: rtl/sga_render_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sga_render_pkg
// Description : Shared renderer FSM state type and default grid geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package sga_render_pkg;

    localparam int c_GRID_W  = 6;
    localparam int c_GRID_H  = 6;
    localparam int c_COORD_W = 3;
    localparam int c_SIZE_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_FETCH  = 3'd2,
        ST_DRAW   = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/led_row_scanner.sv
`default_nettype none
// ============================================================================
// Module      : led_row_scanner
// Description : Free-running row multiplexer for the committed LED frame,
//               with optional apple blink (SGA_APPLE_BLINK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module led_row_scanner #(
    parameter int GRID_W    = 6,
    parameter int GRID_H    = 6,
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 12_500_000
) (
    input  logic                     clock,
    input  logic                     restart,
    input  logic [GRID_W*GRID_H-1:0] leds,
`ifdef SGA_APPLE_BLINK_EN
    input  logic [GRID_W*GRID_H-1:0] apple_mask,
    input  logic [GRID_W*GRID_H-1:0] body_mask,
`endif
    output logic [GRID_H-1:0]        row_sel,
    output logic [GRID_W-1:0]        col_data
);

    localparam int c_ROW_W  = (GRID_H > 1) ? $clog2(GRID_H) : 1;
    localparam int c_SCAN_W = $clog2(SCAN_DIV + 1);

    logic [c_SCAN_W-1:0]          r_scan_cnt;
    logic [c_ROW_W-1:0]           r_row;
    logic [GRID_W*GRID_H-1:0]     w_visible;

    always_ff @(posedge clock) begin
        if (restart) begin
            r_scan_cnt <= '0;
            r_row      <= '0;
        end else if (r_scan_cnt == c_SCAN_W'(SCAN_DIV - 1)) begin
            r_scan_cnt <= '0;
            r_row      <= (r_row == c_ROW_W'(GRID_H - 1)) ? '0 : r_row + c_ROW_W'(1);
        end else begin
            r_scan_cnt <= r_scan_cnt + c_SCAN_W'(1);
        end
    end

`ifdef SGA_APPLE_BLINK_EN
    localparam int c_BLINK_W = $clog2(BLINK_DIV + 1);

    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic                 r_blink_off;

    always_ff @(posedge clock) begin
        if (restart) begin
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
        end else if (r_blink_cnt == c_BLINK_W'(BLINK_DIV - 1)) begin
            r_blink_cnt <= '0;
            r_blink_off <= ~r_blink_off;
        end else begin
            r_blink_cnt <= r_blink_cnt + c_BLINK_W'(1);
        end
    end

    // A body segment sitting on the apple keeps that pixel lit in the off phase.
    assign w_visible = r_blink_off ? (leds & ~(apple_mask & ~body_mask)) : leds;
`else
    assign w_visible = leds;

    // BLINK_DIV has no effect in this build; referenced so both builds share one parameter set.
    if (BLINK_DIV < 1) begin : g_blink_div_unused
    end
`endif

    always_comb begin
        row_sel  = '0;
        col_data = '0;
        for (int r = 0; r < GRID_H; r++) begin
            if (r_row == c_ROW_W'(r)) begin
                row_sel[r] = 1'b1;
                col_data   = w_visible[r*GRID_W +: GRID_W];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/snake_frame_renderer.sv
`default_nettype none
// ============================================================================
// Module      : snake_frame_renderer
// Description : Renders apple + snake body into a double-buffered LED frame
//               and row-scans it. Option macro: SGA_APPLE_BLINK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_frame_renderer
    import sga_render_pkg::*;
#(
    parameter int GRID_W    = c_GRID_W,
    parameter int GRID_H    = c_GRID_H,
    parameter int COORD_W   = c_COORD_W,
    parameter int SIZE_W    = c_SIZE_W,
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 12_500_000
) (
    input  logic                     clock,
    input  logic                     restart,
    input  logic                     render,
    input  logic [SIZE_W-1:0]        size,
    input  logic [COORD_W-1:0]       appleX,
    input  logic [COORD_W-1:0]       appleY,
    output logic [SIZE_W-1:0]        body_addr,
    input  logic [COORD_W-1:0]       body_x,
    input  logic [COORD_W-1:0]       body_y,
    output logic [GRID_W*GRID_H-1:0] leds,
    output logic                     busy,
    output logic                     done,
    output logic                     self_hit,
    output logic [GRID_H-1:0]        row_sel,
    output logic [GRID_W-1:0]        col_data
);

    localparam int c_CELLS = GRID_W * GRID_H;

    // One-hot cell mask; out-of-grid coordinates simply match no cell.
    function automatic logic [c_CELLS-1:0] cell_mask(input logic [COORD_W-1:0] x,
                                                     input logic [COORD_W-1:0] y);
        logic [c_CELLS-1:0] m;
        m = '0;
        for (int cy = 0; cy < GRID_H; cy++)
            for (int cx = 0; cx < GRID_W; cx++)
                if (x == COORD_W'(cx) && y == COORD_W'(cy))
                    m[cy*GRID_W + cx] = 1'b1;
        return m;
    endfunction

    state_t               r_state,     w_state_nxt;
    logic [SIZE_W-1:0]    r_idx,       w_idx_nxt;
    logic [SIZE_W-1:0]    r_size,      w_size_nxt;
    logic [SIZE_W-1:0]    r_body_addr, w_body_addr_nxt;
    logic [c_CELLS-1:0]   r_work,      w_work_nxt;
    logic [c_CELLS-1:0]   r_head,      w_head_nxt;
    logic [c_CELLS-1:0]   r_leds,      w_leds_nxt;
    logic                 r_hit,       w_hit_nxt;
    logic                 r_self_hit,  w_self_hit_nxt;
    logic                 r_done,      w_done_nxt;
    logic [c_CELLS-1:0]   w_body_cell;
    logic [c_CELLS-1:0]   w_apple_cell;
`ifdef SGA_APPLE_BLINK_EN
    logic [c_CELLS-1:0]   r_work_body,  w_work_body_nxt;
    logic [c_CELLS-1:0]   r_body_leds,  w_body_leds_nxt;
    logic [c_CELLS-1:0]   r_apple_work, w_apple_work_nxt;
    logic [c_CELLS-1:0]   r_apple_leds, w_apple_leds_nxt;
`endif

    assign w_body_cell  = cell_mask(body_x, body_y);
    assign w_apple_cell = cell_mask(appleX, appleY);

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_size_nxt      = r_size;
        w_body_addr_nxt = r_body_addr;
        w_work_nxt      = r_work;
        w_head_nxt      = r_head;
        w_leds_nxt      = r_leds;
        w_hit_nxt       = r_hit;
        w_self_hit_nxt  = r_self_hit;
        w_done_nxt      = 1'b0;
`ifdef SGA_APPLE_BLINK_EN
        w_work_body_nxt  = r_work_body;
        w_body_leds_nxt  = r_body_leds;
        w_apple_work_nxt = r_apple_work;
        w_apple_leds_nxt = r_apple_leds;
`endif
        case (r_state)
            ST_IDLE: begin
                if (render) w_state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                w_work_nxt  = w_apple_cell;
                w_head_nxt  = '0;
                w_idx_nxt   = '0;
                w_hit_nxt   = 1'b0;
                w_size_nxt  = size;
                w_state_nxt = (size == '0) ? ST_COMMIT : ST_FETCH;
`ifdef SGA_APPLE_BLINK_EN
                w_work_body_nxt  = '0;
                w_apple_work_nxt = w_apple_cell;
`endif
            end
            ST_FETCH: begin
                w_body_addr_nxt = r_idx;
                w_state_nxt     = ST_DRAW;
            end
            ST_DRAW: begin
                w_work_nxt = r_work | w_body_cell;
`ifdef SGA_APPLE_BLINK_EN
                w_work_body_nxt = r_work_body | w_body_cell;
`endif
                if (r_idx == '0)
                    w_head_nxt = w_body_cell;
                else if ((w_body_cell & r_head) != '0)
                    w_hit_nxt = 1'b1;
                w_idx_nxt   = r_idx + SIZE_W'(1);
                w_state_nxt = (r_idx == r_size - SIZE_W'(1)) ? ST_COMMIT : ST_FETCH;
            end
            ST_COMMIT: begin
                w_leds_nxt     = r_work;
                w_self_hit_nxt = r_hit;
                w_done_nxt     = 1'b1;
                w_state_nxt    = ST_IDLE;
`ifdef SGA_APPLE_BLINK_EN
                w_body_leds_nxt  = r_work_body;
                w_apple_leds_nxt = r_apple_work;
`endif
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (restart) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_size      <= '0;
            r_body_addr <= '0;
            r_work      <= '0;
            r_head      <= '0;
            r_leds      <= '0;
            r_hit       <= 1'b0;
            r_self_hit  <= 1'b0;
            r_done      <= 1'b0;
`ifdef SGA_APPLE_BLINK_EN
            r_work_body  <= '0;
            r_body_leds  <= '0;
            r_apple_work <= '0;
            r_apple_leds <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_size      <= w_size_nxt;
            r_body_addr <= w_body_addr_nxt;
            r_work      <= w_work_nxt;
            r_head      <= w_head_nxt;
            r_leds      <= w_leds_nxt;
            r_hit       <= w_hit_nxt;
            r_self_hit  <= w_self_hit_nxt;
            r_done      <= w_done_nxt;
`ifdef SGA_APPLE_BLINK_EN
            r_work_body  <= w_work_body_nxt;
            r_body_leds  <= w_body_leds_nxt;
            r_apple_work <= w_apple_work_nxt;
            r_apple_leds <= w_apple_leds_nxt;
`endif
        end
    end

    assign leds      = r_leds;
    assign self_hit  = r_self_hit;
    assign done      = r_done;
    assign body_addr = r_body_addr;
    assign busy      = (r_state != ST_IDLE);

    led_row_scanner #(
        .GRID_W    (GRID_W),
        .GRID_H    (GRID_H),
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) u_scanner (
        .clock      (clock),
        .restart    (restart),
        .leds       (r_leds),
`ifdef SGA_APPLE_BLINK_EN
        .apple_mask (r_apple_leds),
        .body_mask  (r_body_leds),
`endif
        .row_sel    (row_sel),
        .col_data   (col_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_snake_frame_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_snake_frame_renderer
// Description : Scoreboard bench: random frames vs. a behavioural frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_frame_renderer;

    localparam int c_GW = 6;
    localparam int c_GH = 6;
    localparam int c_CW = 3;
    localparam int c_SW = 4;
    localparam int c_SD = 2;
    localparam int c_BD = 4;
    localparam int c_N  = c_GW * c_GH;

    logic             clock   = 1'b0;
    logic             restart = 1'b1;
    logic             render  = 1'b0;
    logic [c_SW-1:0]  size    = '0;
    logic [c_CW-1:0]  appleX  = '0;
    logic [c_CW-1:0]  appleY  = '0;
    logic [c_SW-1:0]  body_addr;
    logic [c_CW-1:0]  body_x, body_y;
    logic [c_N-1:0]   leds;
    logic             busy, done, self_hit;
    logic [c_GH-1:0]  row_sel;
    logic [c_GW-1:0]  col_data;

    logic [c_CW-1:0]  mem_x [16];
    logic [c_CW-1:0]  mem_y [16];

    assign body_x = mem_x[body_addr];
    assign body_y = mem_y[body_addr];

    snake_frame_renderer #(
        .GRID_W(c_GW), .GRID_H(c_GH), .COORD_W(c_CW), .SIZE_W(c_SW),
        .SCAN_DIV(c_SD), .BLINK_DIV(c_BD)
    ) dut (
        .clock(clock), .restart(restart), .render(render), .size(size),
        .appleX(appleX), .appleY(appleY), .body_addr(body_addr),
        .body_x(body_x), .body_y(body_y), .leds(leds), .busy(busy),
        .done(done), .self_hit(self_hit), .row_sel(row_sel), .col_data(col_data)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    typedef struct {
        logic [c_N-1:0] leds;
        logic           hit;
        int             due;
    } exp_t;

    exp_t           sbq[$];
    int             checks = 0;
    int             failures = 0;
    int             reset_edge = 0;
    logic [c_N-1:0] m_leds = '0;
    logic [c_N-1:0] m_body = '0;
    logic [c_N-1:0] m_apple = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame model: apple pixel plus every in-grid segment; hit if any later segment lands on the head.
    function automatic void model(input int n, input int ax, input int ay,
                                  output logic [c_N-1:0] fl, output logic [c_N-1:0] fb,
                                  output logic [c_N-1:0] fa, output logic fh);
        fa = '0; fb = '0; fh = 1'b0;
        if (ax < c_GW && ay < c_GH) fa[ay*c_GW + ax] = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (int'(mem_x[i]) < c_GW && int'(mem_y[i]) < c_GH) begin
                fb[int'(mem_y[i])*c_GW + int'(mem_x[i])] = 1'b1;
                if (i > 0 && mem_x[i] == mem_x[0] && mem_y[i] == mem_y[0]) fh = 1'b1;
            end
        end
        fl = fa | fb;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding frame.
    always @(negedge clock) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                e = sbq.pop_front();
                check("frame_leds", 64'(leds), 64'(e.leds));
                check("frame_self_hit", 64'(self_hit), 64'(e.hit));
                check("done_edge", 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic run_frame(input int n, input int ax, input int ay, input bit repulse);
        logic [c_N-1:0] fl, fb, fa;
        logic           fh;
        int             b;
        model(n, ax, ay, fl, fb, fa, fh);
        size   = c_SW'(n);
        appleX = c_CW'(ax);
        appleY = c_CW'(ay);
        @(posedge clock); #1;
        render = 1'b1;
        sbq.push_back('{leds: fl, hit: fh, due: cyc + 1 + 2*n + 2});
        @(posedge clock); #1;
        render  = 1'b0;
        m_leds  = fl;
        m_body  = fb;
        m_apple = fa;
        b = 0;
        while (busy === 1'b1 && b < 200) begin
            b++;
            render = repulse && (b == 2);
            @(posedge clock); #1;
        end
        render = 1'b0;
        check("busy_cycles", 64'(b), 64'(2*n + 2));
        @(negedge clock);
    endtask

    task automatic scan_check(input int cycles);
        int             row;
        logic [c_N-1:0] vis;
        logic [c_GW-1:0] ecol;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            row = ((cyc - reset_edge) / c_SD) % c_GH;
            vis = m_leds;
`ifdef SGA_APPLE_BLINK_EN
            if (((cyc - reset_edge) / c_BD) % 2 == 1) vis = vis & ~(m_apple & ~m_body);
`endif
            ecol = vis[row*c_GW +: c_GW];
            check("row_sel", 64'(row_sel), 64'd1 << row);
            check("col_data", 64'(col_data), 64'(ecol));
        end
    endtask

    task automatic set_body(input int i, input int x, input int y);
        mem_x[i] = c_CW'(x);
        mem_y[i] = c_CW'(y);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16; i++) set_body(i, 7, 7);
        repeat (2) @(posedge clock);
        #1 restart = 1'b0;
        reset_edge = cyc;
        @(negedge clock);
        check("rst_leds", 64'(leds), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_self_hit", 64'(self_hit), 64'd0);
        check("rst_body_addr", 64'(body_addr), 64'd0);
        check("rst_row_sel", 64'(row_sel), 64'd1);

        run_frame(0, 2, 3, 1'b0);
        check("size0_leds", 64'(leds), 64'd1 << 20);

        set_body(0, 1, 1); set_body(1, 1, 2); set_body(2, 1, 3);
        run_frame(3, 4, 4, 1'b0);
        check("body3_leds", 64'(leds), (64'd1 << 7) | (64'd1 << 13) | (64'd1 << 19) | (64'd1 << 28));
        scan_check(14);

        set_body(0, 6, 0); set_body(1, 0, 5);
        run_frame(2, 7, 7, 1'b0);
        check("range_leds", 64'(leds), 64'd1 << 30);

        set_body(0, 2, 2); set_body(1, 2, 3); set_body(2, 2, 2);
        run_frame(3, 7, 7, 1'b1);
        check("hit_leds", 64'(leds), (64'd1 << 14) | (64'd1 << 20));
        check("hit_flag", 64'(self_hit), 64'd1);
        scan_check(14);

        for (int k = 0; k < 24; k++) begin
            n = (k == 5) ? 15 : int'($urandom_range(0, 15));
            for (int i = 0; i < 16; i++) set_body(i, $urandom_range(0, 7), $urandom_range(0, 7));
            if (n > 1 && $urandom_range(0, 2) == 0) set_body($urandom_range(1, n - 1), mem_x[0], mem_y[0]);
            run_frame(n, $urandom_range(0, 7), $urandom_range(0, 7), (k % 3) == 0);
            if (k % 6 == 0) scan_check(8);
        end

        // Abort a size-5 frame with restart sampled three edges after render.
        for (int i = 0; i < 16; i++) set_body(i, $urandom_range(0, 5), $urandom_range(0, 5));
        size = 5; appleX = 1; appleY = 1;
        @(posedge clock); #1 render = 1'b1;
        @(posedge clock); #1 render = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1 restart = 1'b1;
        @(posedge clock); #1 restart = 1'b0;
        reset_edge = cyc;
        m_leds = '0; m_body = '0; m_apple = '0;
        @(negedge clock);
        check("abort_leds", 64'(leds), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_self_hit", 64'(self_hit), 64'd0);
        check("abort_row_sel", 64'(row_sel), 64'd1);
        scan_check(20);

        check("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
